// File: rtl/viterbi_seq_ctrl.sv
// Viterbi decoder sequencing controller: walks a frame through encode or
// branch-metric/ACS/trellis-fill/traceback/flush phases and drives stage enables.
`ifndef DECODE_MODE
`define DECODE_MODE 1'b1
`endif

module viterbi_seq_ctrl #(
  parameter int TB_DEPTH    = 16,
  parameter int BM_PRECALC  = 4,
  parameter int FRAME_LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   i_mode_sel,
  input  logic                   i_start,
  input  logic [FRAME_LEN_W-1:0] i_frame_len,
  input  logic                   i_out_ready,
  output logic                   o_en_ce,
  output logic                   o_en_s,
  output logic                   o_en_bm,
  output logic                   o_en_acs,
  output logic                   o_en_td,
  output logic                   o_en_t,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ENC    = 4'd1;
  localparam logic [3:0] S_BM_PRE = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_ACS    = 4'd4;
  localparam logic [3:0] S_FILL   = 4'd5;
  localparam logic [3:0] S_TRACE  = 4'd6;
  localparam logic [3:0] S_FLUSH  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam int DEP_W = $clog2(TB_DEPTH + 1);
  localparam int PRE_W = $clog2(BM_PRECALC + 1);
  localparam logic [DEP_W-1:0] DEP_FULL = DEP_W'(TB_DEPTH);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BM_PRECALC - 1);

  logic [3:0]             state_q, state_d;
  logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
  logic [FRAME_LEN_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [DEP_W-1:0]       dep_cnt_q, dep_cnt_d;
  logic [FRAME_LEN_W-1:0] len_q, len_d;

  logic [FRAME_LEN_W-1:0] sym_inc;
  logic [DEP_W-1:0]       dep_inc;
  logic                   last_sym;

  assign sym_inc  = sym_cnt_q + 1'b1;
  assign dep_inc  = dep_cnt_q + 1'b1;
  assign last_sym = (sym_inc == len_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    sym_cnt_d = sym_cnt_q;
    dep_cnt_d = dep_cnt_q;
    len_d     = len_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (i_start && (i_frame_len != '0)) begin
            len_d     = i_frame_len;
            pre_cnt_d = '0;
            sym_cnt_d = '0;
            dep_cnt_d = '0;
            state_d   = (i_mode_sel == `DECODE_MODE) ? S_BM_PRE : S_ENC;
          end
        end
        S_ENC: begin
          sym_cnt_d = sym_inc;
          if (last_sym) state_d = S_DONE;
        end
        S_BM_PRE: begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q == PRE_LAST) state_d = S_LOAD;
        end
        S_LOAD: state_d = S_ACS;
        S_ACS:  state_d = S_FILL;
        S_FILL: begin
          sym_cnt_d = sym_inc;
          dep_cnt_d = dep_inc;
          // End of frame wins over a full trellis: short frames go straight to flush.
          if (last_sym)                  state_d = S_FLUSH;
          else if (dep_inc == DEP_FULL)  state_d = S_TRACE;
        end
        S_TRACE: begin
          if (i_out_ready) begin
            sym_cnt_d = sym_inc;
            if (last_sym) begin
              state_d   = S_FLUSH;
              dep_cnt_d = DEP_FULL;
            end
          end
        end
        S_FLUSH: begin
          if (i_out_ready) begin
            dep_cnt_d = dep_cnt_q - 1'b1;
            if (dep_cnt_q <= DEP_W'(1)) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      sym_cnt_q <= '0;
      dep_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      dep_cnt_q <= dep_cnt_d;
      len_q     <= len_d;
    end
  end

  always_comb begin
    o_en_ce  = 1'b0;
    o_en_s   = 1'b0;
    o_en_bm  = 1'b0;
    o_en_acs = 1'b0;
    o_en_td  = 1'b0;
    o_en_t   = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    if (en) begin
      case (state_q)
        S_ENC: begin
          o_busy  = 1'b1;
          o_en_ce = 1'b1;
        end
        S_BM_PRE: begin
          o_busy  = 1'b1;
          o_en_ce = 1'b1;
          o_en_bm = 1'b1;
        end
        S_LOAD: begin
          o_busy  = 1'b1;
          o_en_ce = 1'b1;
          o_en_s  = 1'b1;
          o_en_bm = 1'b1;
        end
        S_ACS: begin
          o_busy   = 1'b1;
          o_en_ce  = 1'b1;
          o_en_s   = 1'b1;
          o_en_bm  = 1'b1;
          o_en_acs = 1'b1;
        end
        S_FILL: begin
          o_busy   = 1'b1;
          o_en_ce  = 1'b1;
          o_en_s   = 1'b1;
          o_en_bm  = 1'b1;
          o_en_acs = 1'b1;
          o_en_td  = 1'b1;
        end
        S_TRACE: begin
          // A downstream stall keeps only the encoder and branch metrics running.
          o_busy   = 1'b1;
          o_en_ce  = 1'b1;
          o_en_bm  = 1'b1;
          o_en_s   = i_out_ready;
          o_en_acs = i_out_ready;
          o_en_td  = i_out_ready;
          o_en_t   = i_out_ready;
        end
        S_FLUSH: begin
          o_busy = 1'b1;
          o_en_t = i_out_ready;
        end
        S_DONE: begin
          o_busy = 1'b1;
          o_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// Directed bench for viterbi_seq_ctrl: run-length table of per-cycle inputs and
// expected outputs {busy, done, ce, s, bm, acs, td, t}, with TB_DEPTH=4, BM_PRECALC=3.
`ifndef DECODE_MODE
`define DECODE_MODE 1'b1
`endif

module tb_viterbi_seq_ctrl;

  localparam int TB_DEPTH    = 4;
  localparam int BM_PRECALC  = 3;
  localparam int FRAME_LEN_W = 16;

  localparam logic [7:0] X_IDLE  = 8'b0_0_000000;
  localparam logic [7:0] X_ENC   = 8'b1_0_100000;
  localparam logic [7:0] X_BMPRE = 8'b1_0_101000;
  localparam logic [7:0] X_LOAD  = 8'b1_0_111000;
  localparam logic [7:0] X_ACS   = 8'b1_0_111100;
  localparam logic [7:0] X_FILL  = 8'b1_0_111110;
  localparam logic [7:0] X_TR_R  = 8'b1_0_111111;
  localparam logic [7:0] X_TR_S  = 8'b1_0_101000;
  localparam logic [7:0] X_FL_R  = 8'b1_0_000001;
  localparam logic [7:0] X_FL_S  = 8'b1_0_000000;
  localparam logic [7:0] X_DONE  = 8'b1_1_000000;

  localparam logic ENC = ~`DECODE_MODE;
  localparam logic DEC = `DECODE_MODE;

  typedef struct {
    int unsigned            n;
    logic                   en;
    logic                   rst;
    logic                   start;
    logic                   mode;
    logic [FRAME_LEN_W-1:0] len;
    logic                   ready;
    logic [7:0]             exp;
  } seg_t;

  logic clk = 1'b0;
  logic rst, en, i_mode_sel, i_start, i_out_ready;
  logic [FRAME_LEN_W-1:0] i_frame_len;
  logic o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_td, o_en_t, o_busy, o_done;

  seg_t segs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  viterbi_seq_ctrl #(
    .TB_DEPTH   (TB_DEPTH),
    .BM_PRECALC (BM_PRECALC),
    .FRAME_LEN_W(FRAME_LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .i_mode_sel (i_mode_sel),
    .i_start    (i_start),
    .i_frame_len(i_frame_len),
    .i_out_ready(i_out_ready),
    .o_en_ce    (o_en_ce),
    .o_en_s     (o_en_s),
    .o_en_bm    (o_en_bm),
    .o_en_acs   (o_en_acs),
    .o_en_td    (o_en_td),
    .o_en_t     (o_en_t),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  task automatic add(input int unsigned n, input logic e, input logic r, input logic s,
                     input logic m, input int l, input logic rdy, input logic [7:0] x);
    seg_t t;
    t.n = n; t.en = e; t.rst = r; t.start = s; t.mode = m;
    t.len = FRAME_LEN_W'(l); t.ready = rdy; t.exp = x;
    segs.push_back(t);
  endtask

  // Plain run-length step: enabled, no reset, no start, ready high.
  task automatic run(input int unsigned n, input logic [7:0] x);
    add(n, 1'b1, 1'b0, 1'b0, ENC, 0, 1'b1, x);
  endtask

  task automatic go(input logic m, input int l);
    add(1, 1'b1, 1'b0, 1'b1, m, l, 1'b1, X_IDLE);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy,done,ce,s,bm,acs,td,t=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // Reset state, then release.
    add(2, 1'b1, 1'b1, 1'b0, ENC, 0, 1'b1, X_IDLE);
    run(1, X_IDLE);

    // Encode, len=5.
    go(ENC, 5); run(5, X_ENC); run(1, X_DONE); run(1, X_IDLE);

    // Decode, len=10; a start with a different length during TRACE is ignored.
    go(DEC, 10); run(3, X_BMPRE); run(1, X_LOAD); run(1, X_ACS); run(4, X_FILL);
    add(6, 1'b1, 1'b0, 1'b1, ENC, 2, 1'b1, X_TR_R);
    run(4, X_FL_R); run(1, X_DONE); run(1, X_IDLE);

    // Decode, len=10, downstream stall in cycles 11-12.
    go(DEC, 10); run(3, X_BMPRE); run(1, X_LOAD); run(1, X_ACS); run(4, X_FILL);
    run(1, X_TR_R);
    add(2, 1'b1, 1'b0, 1'b0, ENC, 0, 1'b0, X_TR_S);
    run(5, X_TR_R); run(4, X_FL_R); run(1, X_DONE); run(1, X_IDLE);

    // Decode, len=2: never traces; one stalled flush cycle delays completion.
    go(DEC, 2); run(3, X_BMPRE); run(1, X_LOAD); run(1, X_ACS); run(2, X_FILL);
    add(1, 1'b1, 1'b0, 1'b0, ENC, 0, 1'b0, X_FL_S);
    run(2, X_FL_R); run(1, X_DONE); run(1, X_IDLE);

    // Decode, len=1: minimal frame.
    go(DEC, 1); run(3, X_BMPRE); run(1, X_LOAD); run(1, X_ACS); run(1, X_FILL);
    run(1, X_FL_R); run(1, X_DONE); run(1, X_IDLE);

    // Decode, len=TB_DEPTH: end of frame takes priority over a full trellis.
    go(DEC, 4); run(3, X_BMPRE); run(1, X_LOAD); run(1, X_ACS); run(4, X_FILL);
    run(4, X_FL_R); run(1, X_DONE); run(1, X_IDLE);

    // Decode, len=10 with en=0 in cycles 7-8.
    go(DEC, 10); run(3, X_BMPRE); run(1, X_LOAD); run(1, X_ACS); run(1, X_FILL);
    add(2, 1'b0, 1'b0, 1'b0, ENC, 0, 1'b1, X_IDLE);
    run(3, X_FILL); run(6, X_TR_R); run(4, X_FL_R); run(1, X_DONE); run(1, X_IDLE);

    // Zero length and a disabled block both ignore start.
    go(ENC, 0); run(2, X_IDLE);
    add(1, 1'b0, 1'b0, 1'b1, ENC, 5, 1'b1, X_IDLE);
    run(1, X_IDLE);

    // Reset mid-TRACE (cycle 12); start held during reset is not taken; then len=3 encode.
    go(DEC, 10); run(3, X_BMPRE); run(1, X_LOAD); run(1, X_ACS); run(4, X_FILL);
    run(2, X_TR_R);
    add(1, 1'b1, 1'b1, 1'b1, ENC, 3, 1'b1, X_IDLE);
    run(1, X_IDLE);
    go(ENC, 3); run(3, X_ENC); run(1, X_DONE); run(1, X_IDLE);

    for (int s = 0; s < segs.size(); s++) begin
      for (int c = 0; c < int'(segs[s].n); c++) begin
        @(negedge clk);
        rst         = segs[s].rst;
        en          = segs[s].en;
        i_start     = segs[s].start;
        i_mode_sel  = segs[s].mode;
        i_frame_len = segs[s].len;
        i_out_ready = segs[s].ready;
        #1;
        check($sformatf("seg%0d.cyc%0d", s, c),
              {o_busy, o_done, o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_td, o_en_t},
              segs[s].exp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
